dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised, byte-addressable data memory with RISC-V load/store semantics. It sits behind the processor's memory stage and is the successor to the plain word-access data memory. It adds:
- configurable depth;
- byte/half/word access with sign/zero extension selected by funct3;
- a request/response handshake with response backpressure;
- misalignment and range fault reporting.

## Interface
Parameters:
- ADDR_W, 12: byte-address width actually decoded; capacity is 2^ADDR_W bytes, organised as 2^(ADDR_W-2) 32-bit words of four byte lanes. Legal range 3..20.

Ports (one clock; reset is synchronous and active-high; the codebase names them `clk` and `rst`):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and faults
- rsp_err  out  1  request faulted (misaligned, out of range, or illegal funct3)

## Operation
FSM with two states, IDLE and RESP.
- **IDLE:**
  - req_ready=1.
  - On req_valid: accept the request, go to RESP, and register rsp_rdata/rsp_err.
- **RESP:**
  - req_ready=0, rsp_valid=1.
  - When rsp_ready=1, return to IDLE.
  - rsp_rdata and rsp_err stay stable while waiting.

Fault check at accept, evaluated in this priority order:
- **Illegal funct3:** 011, 110 or 111 with req_we=0; any of 011, 100, 101, 110, 111 with req_we=1.
- **Misaligned:** half access with addr[0]=1; word access with addr[1:0]≠00.
- **Out of range:** req_addr[31:ADDR_W] ≠ 0.
- **Faulted request:** rsp_err=1, rsp_rdata=0, memory unchanged.

Store (no fault):
- The store is written on the accept edge.
- Only the addressed lanes are written:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0], little-endian.
  - SW writes all four lanes.
- Other lanes keep their contents.
- Response: rsp_rdata=0, rsp_err=0.

Load (no fault):
- Read word index addr[ADDR_W-1:2] on the accept edge.
- Select the byte or half by addr[1:0].
- LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.

Memory array is NOT cleared by rst. Contents are undefined until written; the bench must not read unwritten locations.

## Timing
- **Reset** (rst high at a clk edge): state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 from the next cycle.
- **Reset mid-operation:** reset while in RESP discards the pending response. A store accepted before reset stays committed.
- **Latency:** accept at edge N → rsp_valid=1 from edge N up to and including the edge where rsp_ready=1 → IDLE.
- **Peak throughput:** one access per 2 cycles (rsp_ready held high).
- **Combinational paths:** req_ready depends on state only, with no combinational path from req_valid or rsp_ready.
- **Read-after-write:** a load accepted on any cycle after a store's accept edge returns the stored data.
- **Don't-care inputs:** request inputs are ignored while in RESP.

## Test plan
- Reset, then SW 0xDEADBEEF @0x010, then LW @0x010 → rsp_rdata=0xDEADBEEF, rsp_err=0; each response is one cycle after accept with rsp_ready=1.
- After the SW, SB 0x7F @0x011, then LB @0x011 → 0x0000007F; LW @0x010 → 0xDEAD7FEF; LBU @0x013 → 0x000000DE; LB @0x013 → 0xFFFFFFDE.
- SH 0x8001 @0x022, then LH @0x022 → 0xFFFF8001; LHU @0x022 → 0x00008001; LW @0x020 shows upper half 0x8001 with the lower half unchanged.
- Fault cases:
  - LH @0x021 → rsp_err=1, rsp_rdata=0.
  - SW @0x012 → rsp_err=1 and memory unchanged, checked by LW @0x010.
  - LW @0x1000 with ADDR_W=12 → rsp_err=1.
  - funct3=011 → rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load → rsp_valid and rsp_rdata stable and req_ready=0 throughout; a req_valid pulse during the stall is ignored; release → IDLE next cycle.
- Reset mid-operation: assert rst while in RESP after a store → rsp_valid=0 and req_ready=1 after the reset edge; a subsequent load returns the stored value.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response bundle between the memory stage
// and the byte-addressable data memory.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-lane data memory with RV32 load/store semantics,
// one-deep response register and fault reporting.
module dmem_lsu #(
  parameter int ADDR_W = 12
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);

  localparam int WORDS = 1 << (ADDR_W - 2);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state_q, state_d;

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [ADDR_W-3:0] idx;
  logic [31:0]       word;
  logic [4:0]        bsh;
  logic [7:0]        b;
  logic [15:0]       h;
  logic [2:0]        f3;
  logic              ill;
  logic              mis;
  logic              oor;
  logic              fault;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [31:0]       ld;
  logic              accept;
  logic              wr_en;

  assign f3   = bus.req_funct3;
  assign idx  = bus.req_addr[ADDR_W-1:2];
  assign word = mem_q[idx];
  assign bsh  = {bus.req_addr[1:0], 3'b000};
  assign b    = word[bsh +: 8];
  assign h    = bus.req_addr[1] ? word[31:16]
                                : word[15:0];
  assign oor  = |(bus.req_addr >> ADDR_W);

  // Fault decode, store lane enables and load extension.
  always_comb begin
    ill   = 1'b0;
    mis   = 1'b0;
    be    = 4'b0000;
    wlane = bus.req_wdata;
    ld    = 32'h0;
    if (bus.req_we)
      ill = (f3 != 3'b000) && (f3 != 3'b001)
         && (f3 != 3'b010);
    else
      ill = (f3 == 3'b011) || (f3 == 3'b110)
         || (f3 == 3'b111);
    if (f3[1:0] == 2'b01)
      mis = bus.req_addr[0];
    else if (f3[1:0] == 2'b10)
      mis = |bus.req_addr[1:0];
    unique case (1'b1)
      (f3 == 3'b000): begin
        be    = 4'b0001 << bus.req_addr[1:0];
        wlane = {4{bus.req_wdata[7:0]}};
        ld    = {{24{b[7]}}, b};
      end
      (f3 == 3'b001): begin
        be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.req_wdata[15:0]}};
        ld    = {{16{h[15]}}, h};
      end
      (f3 == 3'b010): begin
        be    = 4'b1111;
        ld    = word;
      end
      (f3 == 3'b100): ld = {24'h0, b};
      (f3 == 3'b101): ld = {16'h0, h};
      default: ld = 32'h0;
    endcase
  end

  assign fault = ill | mis | oor;

  // Next state, accept strobe and response capture.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = RESP;
          err_d   = fault;
          rdata_d = (fault | bus.req_we) ? 32'h0 : ld;
        end
      end
      RESP: begin
        if (bus.rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en = accept & bus.req_we & ~fault & ~rst;

  // State and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Lane-masked store; the array is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed vector table plus backpressure
// and mid-response reset sequences.
module tb_dmem_lsu;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_lsu_if bus();

  dmem_lsu #(.ADDR_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic we,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  task automatic idle_in();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
  endtask

  // one transaction with rsp_ready held high
  task automatic xact(input vec_t v);
    @(negedge clk);
    chk({v.name, ".ready_in"},
        {31'h0, bus.req_ready}, 32'h1);
    drive(v.we, v.f3, v.addr, v.wdata);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    idle_in();
    chk({v.name, ".valid"},
        {31'h0, bus.rsp_valid}, 32'h1);
    chk({v.name, ".rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({v.name, ".err"},
        {31'h0, bus.rsp_err}, {31'h0, v.exp_err});
    @(posedge clk);
    #1;
    chk({v.name, ".back_idle"},
        {31'h0, bus.req_ready}, 32'h1);
  endtask

  vec_t tv [$];
  vec_t v;
  logic [31:0] held;

  initial begin
    tv.push_back('{"sw10",  1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        0});
    tv.push_back('{"lw10",  0, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 0});
    tv.push_back('{"sb11",  1, 3'b000, 32'h011, 32'hFFFFFF7F, 32'h0,        0});
    tv.push_back('{"lb11",  0, 3'b000, 32'h011, 32'h0,        32'h0000007F, 0});
    tv.push_back('{"lw10b", 0, 3'b010, 32'h010, 32'h0,        32'hDEAD7FEF, 0});
    tv.push_back('{"lbu13", 0, 3'b100, 32'h013, 32'h0,        32'h000000DE, 0});
    tv.push_back('{"lb13",  0, 3'b000, 32'h013, 32'h0,        32'hFFFFFFDE, 0});
    tv.push_back('{"sw20",  1, 3'b010, 32'h020, 32'h11223344, 32'h0,        0});
    tv.push_back('{"sh22",  1, 3'b001, 32'h022, 32'hABCD8001, 32'h0,        0});
    tv.push_back('{"lh22",  0, 3'b001, 32'h022, 32'h0,        32'hFFFF8001, 0});
    tv.push_back('{"lhu22", 0, 3'b101, 32'h022, 32'h0,        32'h00008001, 0});
    tv.push_back('{"lw20",  0, 3'b010, 32'h020, 32'h0,        32'h80013344, 0});
    tv.push_back('{"lh21",  0, 3'b001, 32'h021, 32'h0,        32'h0,        1});
    tv.push_back('{"sw12",  1, 3'b010, 32'h012, 32'hCAFEF00D, 32'h0,        1});
    tv.push_back('{"lw10c", 0, 3'b010, 32'h010, 32'h0,        32'hDEAD7FEF, 0});
    tv.push_back('{"lw1000",0, 3'b010, 32'h1000,32'h0,        32'h0,        1});
    tv.push_back('{"f3_011",0, 3'b011, 32'h010, 32'h0,        32'h0,        1});
    tv.push_back('{"s_f100",1, 3'b100, 32'h010, 32'h0,        32'h0,        1});
    tv.push_back('{"lhu13", 0, 3'b101, 32'h013, 32'h0,        32'h0,        1});
    tv.push_back('{"lw10d", 0, 3'b010, 32'h010, 32'h0,        32'hDEAD7FEF, 0});
    tv.push_back('{"swffc", 1, 3'b010, 32'hFFC, 32'h01020304, 32'h0,        0});
    tv.push_back('{"lbuffe",0, 3'b100, 32'hFFE, 32'h0,        32'h00000002, 0});
    tv.push_back('{"lhffe", 0, 3'b001, 32'hFFE, 32'h0,        32'h00000102, 0});
    tv.push_back('{"lb12",  0, 3'b000, 32'h012, 32'h0,        32'hFFFFFFAD, 0});

    rst = 1'b1;
    idle_in();
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst.ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst.rdata", bus.rsp_rdata, 32'h0);
    chk("rst.err", {31'h0, bus.rsp_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++)
      xact(tv[i]);

    // backpressure: stall five cycles, stray request ignored
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(1'b0, 3'b010, 32'h020, 32'h0);
    @(posedge clk);
    #1;
    idle_in();
    chk("bp.valid0", {31'h0, bus.rsp_valid}, 32'h1);
    chk("bp.rdata0", bus.rsp_rdata, 32'h80013344);
    held = bus.rsp_rdata;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2)
        drive(1'b1, 3'b010, 32'h010, 32'h0);
      else
        idle_in();
      @(posedge clk);
      #1;
      chk("bp.valid", {31'h0, bus.rsp_valid}, 32'h1);
      chk("bp.ready", {31'h0, bus.req_ready}, 32'h0);
      chk("bp.rdata", bus.rsp_rdata, held);
      chk("bp.err", {31'h0, bus.rsp_err}, 32'h0);
    end
    @(negedge clk);
    idle_in();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.rel_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("bp.rel_ready", {31'h0, bus.req_ready}, 32'h1);
    v = '{"bp.after", 0, 3'b010, 32'h010, 32'h0, 32'hDEAD7FEF, 0};
    xact(v);

    // reset while a store response is pending
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(1'b1, 3'b010, 32'h030, 32'h5A5A1234);
    @(posedge clk);
    #1;
    idle_in();
    chk("mr.valid", {31'h0, bus.rsp_valid}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mr.valid0", {31'h0, bus.rsp_valid}, 32'h0);
    chk("mr.ready1", {31'h0, bus.req_ready}, 32'h1);
    chk("mr.rdata0", bus.rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    v = '{"mr.lw30", 0, 3'b010, 32'h030, 32'h0, 32'h5A5A1234, 0};
    xact(v);
    v = '{"mr.lbu32", 0, 3'b100, 32'h032, 32'h0, 32'h0000005A, 0};
    xact(v);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
